sseg_scan_ctrl: RTL and testbench

Scan scheduler and digit register bank for the Nexys3 four-digit seven-segment display. It owns the multiplexing: it holds one nibble and decimal-point bit per digit, written through a valid/ready port. It time-slices the four digits at a programmable refresh rate and inserts an all-off blanking interval before every digit to suppress ghosting. It drives the digit-select index, the nibble and dp for the per-digit segment decoder, and the active-low anode lines.

---
 rtl/sseg_scan_ctrl.sv | 99 +++++++++
 tb/tb_sseg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment scan scheduler: four-entry digit bank with a valid/ready write port,
// per-slot blanking interval, leading-zero / force-off suppression and registered anodes.
module sseg_scan_ctrl #(
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_digit,
   input  logic [3:0] wr_data,
   input  logic       wr_dp,
   input  logic [3:0] blank_en,
   input  logic       lz_en,
   output logic [1:0] digit_sel,
   output logic [3:0] digit_val,
   output logic       dp,
   output logic [3:0] sseg_an,
   output logic       frame_tick
);

   localparam int unsigned CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      sel, sel_nxt;
   logic [3:0][3:0] bank_nib, nib_nxt;
   logic [3:0]      bank_dp, dp_nxt;
   logic [3:0]      zero_run;
   logic [3:0]      an_nxt;
   logic            wr_fire, wrap, supp;

   assign wr_ready  = (state == BLANK) && !rst;
   assign wr_fire   = wr_valid && wr_ready;
   assign digit_sel = sel;
   assign digit_val = bank_nib[sel];
   assign dp        = bank_dp[sel];

   always_comb begin
      nib_nxt = bank_nib;
      dp_nxt  = bank_dp;
      if (wr_fire) begin
         nib_nxt[wr_digit] = wr_data;
         dp_nxt[wr_digit]  = wr_dp;
      end

      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      sel_nxt   = sel;
      wrap      = 1'b0;
      case (state)
         BLANK: if (cnt == BLANK_LAST) state_nxt = SHOW;
         SHOW: if (cnt == SLOT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            sel_nxt   = sel + 2'd1;
            wrap      = (sel == 2'd3);
         end
         default: state_nxt = BLANK;
      endcase

      // Suppression looks at the bank as it will be after this edge, so a write in
      // the last BLANK cycle already counts for the first SHOW cycle.
      zero_run[0] = (nib_nxt[0] == 4'd0);
      for (int unsigned i = 1; i < 4; i++)
         zero_run[i] = zero_run[i-1] && (nib_nxt[i] == 4'd0);
      supp = blank_en[sel_nxt] || (lz_en && (sel_nxt != 2'd3) && zero_run[sel_nxt]);

      an_nxt = '1;
      if (state_nxt == SHOW && !supp)
         an_nxt = ~(4'b0001 << sel_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BLANK;
         cnt        <= '0;
         sel        <= '0;
         bank_nib   <= '0;
         bank_dp    <= '0;
         sseg_an    <= '1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sel        <= sel_nxt;
         bank_nib   <= nib_nxt;
         bank_dp    <= dp_nxt;
         sseg_an    <= an_nxt;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a cycle-position reference model predicts every
// output per cycle; a negedge monitor pops and compares.
module tb_sseg_scan_ctrl;

   localparam int SLOT  = 8;
   localparam int BLANK = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [1:0] wr_digit = '0;
   logic [3:0] wr_data = '0;
   logic       wr_dp = 1'b0;
   logic [3:0] blank_en = '0;
   logic       lz_en = 1'b0;
   logic [1:0] digit_sel;
   logic [3:0] digit_val;
   logic       dp;
   logic [3:0] sseg_an;
   logic       frame_tick;

   always #5 clk = ~clk;

   sseg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_digit(wr_digit), .wr_data(wr_data), .wr_dp(wr_dp),
      .blank_en(blank_en), .lz_en(lz_en), .digit_sel(digit_sel),
      .digit_val(digit_val), .dp(dp), .sseg_an(sseg_an), .frame_tick(frame_tick)
   );

   typedef struct {
      logic       chk_all;
      logic       ready;
      logic [1:0] sel;
      logic [3:0] val;
      logic       dpv;
      logic [3:0] an;
      logic       ft;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: time since reset, bank contents, previous-cycle suppression inputs.
   int         t = 0;
   logic [3:0] mb_nib[4];
   logic       mb_dp[4];
   logic [3:0] prev_be = '0;
   logic       prev_lz = 1'b0;
   logic       known = 1'b0;

   task automatic step(input logic r, input logic v, input logic [1:0] d,
                       input logic [3:0] data, input logic wdp,
                       input logic [3:0] be, input logic lz, output logic accepted);
      exp_t e;
      int   pos, slot, lead;
      @(posedge clk);
      #1;
      rst = r; wr_valid = v; wr_digit = d; wr_data = data; wr_dp = wdp;
      blank_en = be; lz_en = lz;

      pos  = t % SLOT;
      slot = (t / SLOT) % 4;
      lead = 0;
      while (lead < 4 && mb_nib[lead] == 4'd0) lead++;

      e.chk_all = known;
      e.ready   = !r && (pos < BLANK);
      e.sel     = 2'(slot);
      e.val     = mb_nib[slot];
      e.dpv     = mb_dp[slot];
      e.ft      = (t > 0) && (t % (4 * SLOT) == 0);
      if (pos < BLANK || prev_be[slot] || (prev_lz && slot < 3 && slot < lead))
         e.an = 4'b1111;
      else
         e.an = ~(4'b0001 << slot);
      sbq.push_back(e);

      accepted = v && e.ready;
      if (r) begin
         t = 0;
         for (int i = 0; i < 4; i++) begin mb_nib[i] = '0; mb_dp[i] = 1'b0; end
         known = 1'b1;
      end else begin
         if (accepted) begin mb_nib[d] = data; mb_dp[d] = wdp; end
         t++;
      end
      prev_be = be;
      prev_lz = lz;
   endtask

   task automatic idle(input int n, input logic [3:0] be, input logic lz);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, be, lz, acc);
   endtask

   task automatic do_reset(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0, acc);
   endtask

   task automatic do_write(input logic [1:0] d, input logic [3:0] data, input logic wdp,
                           input logic [3:0] be, input logic lz);
      logic acc;
      int   n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 2 * SLOT) begin
         step(1'b0, 1'b1, d, data, wdp, be, lz, acc);
         n++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL write_accept: got none within %0d cycles, required acceptance", n);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
      end
   endtask

   exp_t me;
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         chk("wr_ready", 32'(wr_ready), 32'(me.ready));
         if (me.chk_all) begin
            chk("digit_sel", 32'(digit_sel), 32'(me.sel));
            chk("digit_val", 32'(digit_val), 32'(me.val));
            chk("dp", 32'(dp), 32'(me.dpv));
            chk("sseg_an", 32'(sseg_an), 32'(me.an));
            chk("frame_tick", 32'(frame_tick), 32'(me.ft));
         end
      end
   end

   initial begin
      logic       acc, r, v, lz;
      logic [3:0] be, data;
      for (int i = 0; i < 4; i++) begin mb_nib[i] = '0; mb_dp[i] = 1'b0; end

      do_reset(3);
      idle(4 * SLOT + 8, 4'd0, 1'b0);

      // Write raised during SHOW of slot 0 stalls into slot 1 BLANK.
      do_reset(1);
      idle(3, 4'd0, 1'b0);
      do_write(2'd2, 4'hA, 1'b1, 4'd0, 1'b0);
      idle(3 * SLOT, 4'd0, 1'b0);

      // Leading zeros: bank {0,0,3,0}, then all zero.
      do_reset(1);
      do_write(2'd2, 4'd3, 1'b0, 4'd0, 1'b1);
      idle(4 * SLOT + 4, 4'd0, 1'b1);
      do_reset(1);
      idle(4 * SLOT + 4, 4'd0, 1'b1);

      // Force-off of digit 1.
      do_reset(1);
      idle(4 * SLOT + 4, 4'b0010, 1'b0);

      // Reset during SHOW of digit 2.
      do_reset(1);
      idle(2 * SLOT + BLANK + 2, 4'd0, 1'b0);
      do_reset(1);
      idle(2 * SLOT + 4, 4'd0, 1'b0);

      // Random traffic.
      be = '0;
      lz = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(199) == 0);
         v = ($urandom_range(2) == 0);
         data = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
         if ($urandom_range(49) == 0) be = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0;
         if ($urandom_range(39) == 0) lz = ~lz;
         step(r, v, 2'($urandom_range(3)), data, 1'($urandom_range(1)), be, lz, acc);
      end

      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
